serial_rx_pin: RTL and testbench

SERIAL_RX_PIN -- requirements
Module: serial_rx_pin

---
 rtl/serial_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/serial_rx_pin.sv | 150 +++++++++++++++
 tb/tb_serial_rx_pin.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: frame shape, default bit
// period and the receiver state encoding.
package serial_pkg;

    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; reset value selectable so
// idle-high lines do not glitch low out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_rx_pin.sv
// 8N1 serial receiver with mid-bit sampling, a single-entry output buffer and
// frame-error / overrun pulses.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for the first low sample
//   ST_START | counting to the middle of the start bit to confirm it
//   ST_DATA  | sampling data bits LSB first
//   ST_STOP  | sampling the stop bit
//   ST_BREAK | bad stop seen; wait for the line to return high
module serial_rx_pin
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit RX_INVERT    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam int              IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(DATA_BITS - 1);

    logic                 w_rx_pin;
    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_xfer;

    rx_state_e            r_state,    w_state_nxt;
    logic [CW-1:0]        r_cnt,      w_cnt_nxt;
    logic [IW-1:0]        r_bit_idx,  w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_load_req, w_load_req;
    logic                 r_ferr_req, w_ferr_req;

    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    assign w_rx_pin = rx_in ^ RX_INVERT;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (w_rx_pin),
        .o_q   (w_rxs)
    );

    assign w_tick = (r_cnt == '0);
    assign w_xfer = r_data_valid && data_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_tick ? CNT_FULL : r_cnt - 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_load_req    = 1'b0;
        w_ferr_req    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt   = ST_START;
                    w_cnt_nxt     = CNT_HALF;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_load_req  = w_rxs;
                    w_ferr_req  = !w_rxs;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_load_req   <= 1'b0;
            r_ferr_req   <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_load_req  <= w_load_req;
            r_ferr_req  <= w_ferr_req;
            r_frame_err <= r_ferr_req;
            // A transfer in the load cycle frees the slot, so no overrun then.
            r_overrun   <= r_load_req && r_data_valid && !w_xfer;
            if (r_load_req && (!r_data_valid || w_xfer)) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
            end else if (w_xfer) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_rx_pin.sv
// Bench for serial_rx_pin: directed frames plus random traffic, compared every
// cycle against an event-timed single-slot buffer model.
module tb_serial_rx_pin;

    localparam int CPB     = 16;
    localparam int LOAD_AT = 156;   // edges from driving the start bit to buffer load

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    serial_rx_pin #(.CLKS_PER_BIT(CPB), .RX_INVERT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected buffer events keyed by the clock edge on which they take effect.
    logic [7:0] load_at[int];
    bit         ferr_at[int];

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] model_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            m_ferr <= ferr_at.exists(cyc + 1);
            m_ovr  <= 1'b0;
            if (m_valid && data_ready) model_q.push_back(m_data);
            if (load_at.exists(cyc + 1)) begin
                if (m_valid && !data_ready) begin
                    m_ovr <= 1'b1;
                end else begin
                    m_data  <= load_at[cyc + 1];
                    m_valid <= 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    bit         chk_en = 1'b0;
    logic [7:0] dut_q[$];
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         v_cycles = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", data_valid, m_valid);
            chk("data_out", data_out, m_data);
            chk("frame_err", frame_err, m_ferr);
            chk("overrun", overrun, m_ovr);
            if (data_valid && data_ready) dut_q.push_back(data_out);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (data_valid) v_cycles++;
            if (data_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = data_valid;
        end
    end

    // Call just after a rising edge; leaves the line at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) load_at[cyc + LOAD_AT] = b;
        else          ferr_at[cyc + LOAD_AT] = 1'b1;
        rx_in = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_in = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_at.delete();
        ferr_at.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int e0;
    int q0;
    int f0;
    int o0;
    bit rand_on;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Single byte, consumer always ready
        data_ready = 1'b1;
        idle(5);
        v_cycles = 0;
        e0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(10);
        chk("a5_rise", rise_cyc, e0 + LOAD_AT);
        chk("a5_vcycles", v_cycles, 1);
        chk("a5_count", dut_q.size(), 1);
        if (dut_q.size() > 0) chk("a5_byte", dut_q[$], 8'hA5);
        chk("a5_ferr", n_ferr, 0);
        chk("a5_ovr", n_ovr, 0);

        // Short low glitch on an idle line
        q0 = dut_q.size();
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(200);
        chk("glitch_count", dut_q.size(), q0);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_ovr", n_ovr, 0);

        // Bad stop bit, line held low, then a good frame once high again
        q0 = dut_q.size();
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("brk_ferr", n_ferr, 1);
        chk("brk_count", dut_q.size(), q0);
        chk("brk_valid", data_valid, 1'b0);
        idle(20);
        send_frame(8'h81, 1'b1);
        idle(10);
        chk("brk_after_count", dut_q.size(), q0 + 1);
        if (dut_q.size() > 0) chk("brk_after_byte", dut_q[$], 8'h81);
        chk("brk_ferr_total", n_ferr, 1);

        // Two bytes with no consumer: first kept, second dropped with overrun
        data_ready = 1'b0;
        q0 = dut_q.size();
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        idle(8);
        send_frame(8'h22, 1'b1);
        idle(10);
        chk("ovr_data", data_out, 8'h11);
        chk("ovr_valid", data_valid, 1'b1);
        chk("ovr_pulses", n_ovr, o0 + 1);

        // 0x11 buffered; consumer ready only on the load cycle of 0x22
        q0 = dut_q.size();
        o0 = n_ovr;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (LOAD_AT - 1) @(posedge clk);
                #1;
                data_ready = 1'b1;
                @(posedge clk);
                #1;
                data_ready = 1'b0;
            end
        join
        idle(10);
        chk("swap_count", dut_q.size(), q0 + 1);
        if (dut_q.size() > 0) chk("swap_out", dut_q[$], 8'h11);
        chk("swap_data", data_out, 8'h22);
        chk("swap_valid", data_valid, 1'b1);
        chk("swap_ovr", n_ovr, o0);
        data_ready = 1'b1;
        idle(5);

        // Reset during data bit 4, then a clean frame
        q0 = dut_q.size();
        f0 = n_ferr;
        o0 = n_ovr;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (CPB * 5 + 8) @(posedge clk);
                #1;
                do_reset();
            end
        join
        idle(30);
        chk("rstmid_count", dut_q.size(), q0);
        chk("rstmid_ferr", n_ferr, f0);
        chk("rstmid_ovr", n_ovr, o0);
        send_frame(8'h5A, 1'b1);
        idle(10);
        chk("rstmid_after", dut_q.size(), q0 + 1);
        if (dut_q.size() > 0) chk("rstmid_byte", dut_q[$], 8'h5A);

        // Random traffic with random consumer back-pressure
        rand_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    logic [7:0] b;
                    logic       sb;
                    b  = 8'($urandom);
                    sb = ($urandom_range(0, 5) != 0);
                    send_frame(b, sb);
                    idle($urandom_range(0, 20) + (sb ? 0 : 8));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    data_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        data_ready = 1'b1;
        idle(20);

        chk("total_count", dut_q.size(), model_q.size());
        for (int i = 0; i < dut_q.size() && i < model_q.size(); i++) begin
            chk("total_byte", dut_q[i], model_q[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
